ifq_line_buffer: RTL and testbench

Instruction fetch queue storage and sequencing stage for the superscalar front end. Accepts whole cache lines (LINE_WORDS instructions each) from the I-cache side and stores up to DEPTH lines in a circular buffer. Issues one instruction per cycle, with its PC, to dispatch over a valid/ready handshake. Word selection inside the head line is an N-input parameterized mux indexed by the internal word offset, so this block owns the storage array and all pointers that drive that select.

---
 rtl/ifq_line_buffer.sv | 108 ++++++++++
 tb/tb_ifq_line_buffer.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifq_line_buffer.sv
// Instruction fetch queue: circular buffer of whole cache lines, issuing one
// instruction per cycle (with its PC) from the head line to dispatch.
module ifq_line_buffer #(
    parameter int DEPTH      = 4,
    parameter int LINE_WORDS = 4,
    parameter int WIDTH      = 32,
    parameter int PC_W       = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic [PC_W-1:0]             flush_pc,
    input  logic                        line_valid,
    input  logic [WIDTH*LINE_WORDS-1:0] line_data,
    input  logic [PC_W-1:0]             line_pc,
    output logic                        line_ready,
    output logic                        inst_valid,
    output logic [WIDTH-1:0]            inst,
    output logic [PC_W-1:0]             inst_pc,
    input  logic                        inst_ready
);

    localparam int IDX_W  = $clog2(DEPTH);
    localparam int PTR_W  = IDX_W + 1;
    localparam int OFF_W  = $clog2(LINE_WORDS);
    localparam int LINE_W = WIDTH * LINE_WORDS;

    logic [LINE_W-1:0] line_mem [DEPTH];
    logic [PC_W-1:0]   pc_mem   [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OFF_W-1:0] off;
    logic [OFF_W-1:0] start_off;

    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;
    logic             last_word;
    logic [OFF_W-1:0] flush_off;
    logic             unused_flush_pc_bits;

    assign wr_idx    = wr_ptr[IDX_W-1:0];
    assign rd_idx    = rd_ptr[IDX_W-1:0];
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_idx == rd_idx) && (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]);
    assign flush_off = flush_pc[OFF_W+1:2];

    assign unused_flush_pc_bits = ^{flush_pc[PC_W-1:OFF_W+2], flush_pc[1:0]};

    assign line_ready = !full;
    assign inst_valid = !empty;
    assign push       = line_valid && line_ready && !flush;
    assign pop        = inst_valid && inst_ready && !flush;
    assign last_word  = (off == OFF_W'(LINE_WORDS - 1));

    // Word select within the head line.
    always_comb begin
        inst = '0;
        for (int unsigned k = 0; k < LINE_WORDS; k++) begin
            if (off == OFF_W'(k)) begin
                inst = line_mem[rd_idx][k*WIDTH +: WIDTH];
            end
        end
    end

    assign inst_pc = pc_mem[rd_idx] + {{(PC_W-OFF_W-2){1'b0}}, off, 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            off       <= '0;
            start_off <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                line_mem[i] <= '0;
                pc_mem[i]   <= '0;
            end
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            start_off <= flush_off;
            off       <= flush_off;
        end else begin
            if (push) begin
                line_mem[wr_idx] <= line_data;
                pc_mem[wr_idx]   <= line_pc;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            // While waiting for the redirect line, off stays parked at start_off.
            if (pop) begin
                start_off <= '0;
                if (last_word) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                    off    <= '0;
                end else begin
                    off <= off + OFF_W'(1);
                end
            end else if (empty) begin
                off <= start_off;
            end
        end
    end

endmodule

// File: tb/tb_ifq_line_buffer.sv
// Scoreboard bench for ifq_line_buffer: accepted lines queue expected
// {inst, pc} pairs, which are compared as dispatch handshakes complete.
module tb_ifq_line_buffer;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic [31:0]  flush_pc = '0;
    logic         line_valid = 1'b0;
    logic [127:0] line_data = '0;
    logic [31:0]  line_pc = '0;
    logic         line_ready;
    logic         inst_valid;
    logic [31:0]  inst;
    logic [31:0]  inst_pc;
    logic         inst_ready = 1'b0;

    int n_run = 0;
    int n_fail = 0;
    int skip = 0;
    logic [63:0] sb[$];

    ifq_line_buffer #(.DEPTH(4), .LINE_WORDS(4), .WIDTH(32), .PC_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .flush_pc(flush_pc),
        .line_valid(line_valid), .line_data(line_data), .line_pc(line_pc),
        .line_ready(line_ready), .inst_valid(inst_valid), .inst(inst),
        .inst_pc(inst_pc), .inst_ready(inst_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation did not finish");
    end

    function automatic logic [127:0] mk_line(input logic [31:0] base);
        logic [127:0] r;
        for (int k = 0; k < 4; k++) r[k*32 +: 32] = base + 32'(k);
        return r;
    endfunction

    // Scoreboard: compare completed issues, then record accepted lines.
    always @(negedge clk) begin
        if (rst_n) begin
            if (flush) begin
                sb.delete();
                skip = int'(flush_pc[3:2]);
            end else begin
                if (inst_valid && inst_ready) begin
                    n_run++;
                    if (sb.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_issue: got inst=%h pc=%h, required none", inst, inst_pc);
                    end else begin
                        logic [63:0] exp;
                        exp = sb.pop_front();
                        if ({inst, inst_pc} !== exp) begin
                            n_fail++;
                            $display("FAIL issue: got inst=%h pc=%h, required inst=%h pc=%h",
                                     inst, inst_pc, exp[63:32], exp[31:0]);
                        end
                    end
                end
                if (line_valid && line_ready) begin
                    for (int k = skip; k < 4; k++)
                        sb.push_back({line_data[k*32 +: 32], line_pc + 32'(k*4)});
                    skip = 0;
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(output bit ok);
        for (int i = 0; i < 100; i++) begin
            if (sb.size() == 0) break;
            next_cycle();
        end
        ok = (sb.size() == 0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) next_cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_run++;
            if ({inst_valid, line_ready, inst, inst_pc} !== {1'b1 ^ 1'b1, 1'b1, 64'h0}) begin
                n_fail++;
                $display("FAIL reset_idle: got valid=%b ready=%b inst=%h pc=%h, required 0 1 0 0",
                         inst_valid, line_ready, inst, inst_pc);
            end
            next_cycle();
        end
    endtask

    task automatic test_single_line();
        bit ok;
        inst_ready = 1'b1;
        line_valid = 1'b1;
        line_data  = mk_line(32'hA0);
        line_pc    = 32'h100;
        next_cycle();
        line_valid = 1'b0;
        @(negedge clk);
        n_run++;
        if (inst_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL push_latency: got inst_valid=%b, required 1", inst_valid);
        end
        next_cycle();
        wait_drain(ok);
        n_run++;
        if (!ok) begin
            n_fail++;
            $display("FAIL single_drain: got %0d pending, required 0", sb.size());
        end
        @(negedge clk);
        n_run++;
        if (inst_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_empty: got inst_valid=%b, required 0", inst_valid);
        end
        next_cycle();
    endtask

    task automatic test_full();
        bit ok;
        inst_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            line_valid = 1'b1;
            line_data  = mk_line(32'h400 + 32'(i*16));
            line_pc    = 32'h400 + 32'(i*16);
            @(negedge clk);
            n_run++;
            if (line_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL fill_ready[%0d]: got %b, required 1", i, line_ready);
            end
            next_cycle();
        end
        line_data = mk_line(32'h440);
        line_pc   = 32'h440;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_run++;
            if (line_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL full_ready[%0d]: got %b, required 0", i, line_ready);
            end
            next_cycle();
        end
        line_valid = 1'b0;
        inst_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            n_run++;
            if (line_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL drain_ready[%0d]: got %b, required 0", j, line_ready);
            end
            next_cycle();
        end
        @(negedge clk);
        n_run++;
        if (line_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL freed_ready: got %b, required 1", line_ready);
        end
        next_cycle();
        wait_drain(ok);
        n_run++;
        if (!ok) begin
            n_fail++;
            $display("FAIL full_drain: got %0d pending, required 0", sb.size());
        end
    endtask

    task automatic test_flush();
        bit ok;
        inst_ready = 1'b0;
        line_valid = 1'b1;
        line_data  = mk_line(32'hE0);
        line_pc    = 32'h500;
        next_cycle();
        flush      = 1'b1;
        flush_pc   = 32'h208;
        inst_ready = 1'b1;
        line_data  = mk_line(32'hF0);
        line_pc    = 32'h600;
        next_cycle();
        flush      = 1'b0;
        line_valid = 1'b0;
        @(negedge clk);
        n_run++;
        if ({inst_valid, line_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL flush_state: got valid=%b ready=%b, required 0 1", inst_valid, line_ready);
        end
        next_cycle();
        line_valid = 1'b1;
        line_data  = mk_line(32'hB0);
        line_pc    = 32'h200;
        next_cycle();
        line_data  = mk_line(32'hC0);
        line_pc    = 32'h210;
        @(negedge clk);
        n_run++;
        if ({inst, inst_pc} !== {32'hB2, 32'h208}) begin
            n_fail++;
            $display("FAIL flush_start: got inst=%h pc=%h, required b2 208", inst, inst_pc);
        end
        next_cycle();
        line_valid = 1'b0;
        wait_drain(ok);
        n_run++;
        if (!ok) begin
            n_fail++;
            $display("FAIL flush_drain: got %0d pending, required 0", sb.size());
        end
    endtask

    task automatic test_stall();
        bit ok;
        bit prev_stall;
        logic [63:0] held;
        bit pat [7] = '{1, 0, 0, 1, 0, 1, 1};
        prev_stall = 1'b0;
        held = '0;
        inst_ready = 1'b0;
        line_valid = 1'b1;
        line_data  = mk_line(32'hD0);
        line_pc    = 32'h300;
        next_cycle();
        line_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            inst_ready = pat[i];
            @(negedge clk);
            if (prev_stall) begin
                n_run++;
                if ({inst, inst_pc} !== held) begin
                    n_fail++;
                    $display("FAIL stall_hold[%0d]: got inst=%h pc=%h, required inst=%h pc=%h",
                             i, inst, inst_pc, held[63:32], held[31:0]);
                end
            end
            held = {inst, inst_pc};
            prev_stall = !pat[i];
            next_cycle();
        end
        wait_drain(ok);
        n_run++;
        if (!ok) begin
            n_fail++;
            $display("FAIL stall_drain: got %0d pending, required 0", sb.size());
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int waits;
        inst_ready = 1'b1;
        for (int n = 0; n < 20; n++) begin
            line_valid = 1'b1;
            line_data  = mk_line(32'h1000 + 32'(n*16));
            line_pc    = 32'h1000 + 32'(n*16);
            waits = 0;
            ok = 1'b0;
            while (!ok && waits < 10) begin
                @(negedge clk);
                waits++;
                ok = line_ready;
                next_cycle();
            end
            if (n >= 5 || !ok) begin
                n_run++;
                if (!ok || waits != 4) begin
                    n_fail++;
                    $display("FAIL steady_accept[%0d]: got %0d cycles (accepted=%b), required 4", n, waits, ok);
                end
            end
        end
        line_valid = 1'b0;
        wait_drain(ok);
        n_run++;
        if (!ok) begin
            n_fail++;
            $display("FAIL b2b_drain: got %0d pending, required 0", sb.size());
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        inst_ready = 1'b0;
        line_valid = 1'b1;
        line_data  = mk_line(32'h800);
        line_pc    = 32'h800;
        next_cycle();
        line_data  = mk_line(32'h810);
        line_pc    = 32'h810;
        next_cycle();
        line_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        n_run++;
        if ({inst_valid, line_ready, inst, inst_pc} !== {1'b0, 1'b1, 64'h0}) begin
            n_fail++;
            $display("FAIL async_reset: got valid=%b ready=%b inst=%h pc=%h, required 0 1 0 0",
                     inst_valid, line_ready, inst, inst_pc);
        end
        sb.delete();
        skip = 0;
        #1 rst_n = 1'b1;
        next_cycle();
        inst_ready = 1'b1;
        line_valid = 1'b1;
        line_data  = mk_line(32'h700);
        line_pc    = 32'h700;
        next_cycle();
        line_valid = 1'b0;
        wait_drain(ok);
        n_run++;
        if (!ok) begin
            n_fail++;
            $display("FAIL reset_recover: got %0d pending, required 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_line();
        test_full();
        test_flush();
        test_stall();
        test_back_to_back();
        test_async_reset();
        repeat (2) next_cycle();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
